// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: datapath widths, special opcodes,
// the fetch timeout and the fetch FSM state type.
package cpu_pkg;

  localparam int DATA_W        = 8;
  localparam int ADDR_W        = 8;
  localparam int FETCH_TIMEOUT = 8;
  localparam int WAIT_W        = $clog2(FETCH_TIMEOUT + 1);

  localparam logic [3:0]        OP_HALT = 4'hF;
  localparam logic [DATA_W-1:0] OP_NOP  = 8'h00;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_t;

  function automatic logic is_halt_op(input logic [DATA_W-1:0] op);
    return op[DATA_W-1 -: 4] == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_pc.sv
// Program counter: load beats increment, and the whole register freezes once
// the core has halted.
module instr_fetch_pc
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_freeze,
  input  logic              i_inc,
  input  logic              i_load,
  input  logic              i_sel,
  input  logic [ADDR_W-1:0] i_reg_target,
  input  logic [ADDR_W-1:0] i_imm_target,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_target;

  assign w_target = i_sel ? i_imm_target : i_reg_target;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
    end else if (!i_freeze) begin
      if (i_load) begin
        r_pc <= w_target;
      end else if (i_inc) begin
        r_pc <= r_pc + 1'b1;
      end
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-deep fetch FSM with a bounded wait on the
// instruction memory, the instruction register and the sticky status flags.
module instr_fetch_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_ir,
  input  logic              inc_pc,
  input  logic              load_pc,
  input  logic              sel_pc,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic [ADDR_W-1:0] imm_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [DATA_W-1:0] opcode,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_valid,
  output logic              fetch_err,
  output logic              halted
);

  fetch_state_t      r_state;
  logic [WAIT_W-1:0] r_wait;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_opcode;
  logic              r_ir_valid;
  logic              r_fetch_err;
  logic              r_halted;
  logic [ADDR_W-1:0] w_pc;

  instr_fetch_pc u_pc (
    .clk          (clk),
    .reset        (reset),
    .i_freeze     (r_halted),
    .i_inc        (inc_pc),
    .i_load       (load_pc),
    .i_sel        (sel_pc),
    .i_reg_target (reg_target),
    .i_imm_target (imm_target),
    .o_pc         (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wait      <= '0;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_opcode    <= OP_NOP;
      r_ir_valid  <= 1'b0;
      r_fetch_err <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load_ir && !r_halted) begin
            r_state    <= ST_FETCH;
            r_req      <= 1'b1;
            r_addr     <= w_pc;
            r_ir_valid <= 1'b0;
            r_wait     <= '0;
          end
        end
        ST_FETCH: begin
          // Data is checked before the timeout so a late response still wins.
          if (imem_valid) begin
            r_opcode   <= imem_rdata;
            r_ir_valid <= 1'b1;
            r_req      <= 1'b0;
            r_state    <= ST_IDLE;
            if (is_halt_op(imem_rdata)) begin
              r_halted <= 1'b1;
            end
          end else if (r_wait == WAIT_W'(FETCH_TIMEOUT - 1)) begin
            r_wait      <= WAIT_W'(FETCH_TIMEOUT);
            r_opcode    <= OP_NOP;
            r_ir_valid  <= 1'b1;
            r_fetch_err <= 1'b1;
            r_req       <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign opcode    = r_opcode;
  assign pc        = w_pc;
  assign ir_valid  = r_ir_valid;
  assign fetch_err = r_fetch_err;
  assign halted    = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vectors, a fetch-transaction model
// compared every cycle, plus literal spot checks on key results.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_ir = 1'b0, inc_pc = 1'b0, load_pc = 1'b0, sel_pc = 1'b0;
  logic [7:0] reg_target = 8'h00, imm_target = 8'h00;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata = 8'h00;
  logic       imem_valid = 1'b0;
  logic [7:0] opcode, pc;
  logic       ir_valid, fetch_err, halted;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Model state: what the fetch unit must expose, tracked per transaction.
  logic [7:0] m_pc = 0, m_opcode = 0, m_addr = 0;
  bit         m_busy = 0, m_irv = 0, m_err = 0, m_halt = 0;
  int         m_waits = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .load_ir    (load_ir),
    .inc_pc     (inc_pc),
    .load_pc    (load_pc),
    .sel_pc     (sel_pc),
    .reg_target (reg_target),
    .imm_target (imm_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .opcode     (opcode),
    .pc         (pc),
    .ir_valid   (ir_valid),
    .fetch_err  (fetch_err),
    .halted     (halted)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [7:0] old_pc;
    old_pc = m_pc;
    if (reset) begin
      m_pc = 0; m_opcode = 0; m_addr = 0;
      m_busy = 0; m_irv = 0; m_err = 0; m_halt = 0; m_waits = 0;
    end else begin
      if (!m_halt) begin
        if (load_pc)     m_pc = sel_pc ? imm_target : reg_target;
        else if (inc_pc) m_pc = 8'((int'(m_pc) + 1) % 256);
      end
      if (!m_busy) begin
        if (load_ir && !m_halt) begin
          m_busy = 1; m_addr = old_pc; m_irv = 0; m_waits = 0;
        end
      end else if (imem_valid) begin
        m_opcode = imem_rdata; m_irv = 1; m_busy = 0;
        if (imem_rdata >= 8'hF0) m_halt = 1;
      end else begin
        m_waits++;
        if (m_waits == 8) begin
          m_opcode = 8'h00; m_irv = 1; m_err = 1; m_busy = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_pc",        pc,                m_pc);
      chk("model_opcode",    opcode,            m_opcode);
      chk("model_imem_addr", imem_addr,         m_addr);
      chk("model_imem_req",  {7'd0, imem_req},  {7'd0, m_busy});
      chk("model_ir_valid",  {7'd0, ir_valid},  {7'd0, m_irv});
      chk("model_fetch_err", {7'd0, fetch_err}, {7'd0, m_err});
      chk("model_halted",    {7'd0, halted},    {7'd0, m_halt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tick(); tick();
    cmp_en = 1'b1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_opcode", opcode, 8'h00);
    chk("rst_req", {7'd0, imem_req}, 8'h00);
    chk("rst_ir_valid", {7'd0, ir_valid}, 8'h00);
    reset = 1'b0;

    // Fetch with one wait cycle
    load_ir = 1; tick(); load_ir = 0;
    chk("f1_req", {7'd0, imem_req}, 8'h01);
    chk("f1_addr", imem_addr, 8'h00);
    tick();
    imem_valid = 1; imem_rdata = 8'h4A; tick(); imem_valid = 0;
    chk("f1_opcode", opcode, 8'h4A);
    chk("f1_ir_valid", {7'd0, ir_valid}, 8'h01);
    chk("f1_err", {7'd0, fetch_err}, 8'h00);

    // PC wrap and load-over-increment priority
    load_pc = 1; sel_pc = 0; reg_target = 8'hFF; tick(); load_pc = 0;
    chk("pc_ff", pc, 8'hFF);
    inc_pc = 1; tick(); inc_pc = 0;
    chk("pc_wrap", pc, 8'h00);
    load_pc = 1; inc_pc = 1; sel_pc = 1; imm_target = 8'h37; tick();
    load_pc = 0; inc_pc = 0;
    chk("pc_prio", pc, 8'h37);

    // PC change during FETCH leaves the fetch address alone; load_ir ignored
    load_pc = 1; sel_pc = 0; reg_target = 8'h10; tick(); load_pc = 0;
    load_ir = 1; tick(); load_ir = 0;
    chk("f2_addr", imem_addr, 8'h10);
    load_pc = 1; reg_target = 8'h80; tick(); load_pc = 0;
    chk("f2_addr_hold", imem_addr, 8'h10);
    load_ir = 1; tick(); load_ir = 0;
    imem_valid = 1; imem_rdata = 8'h25; tick(); imem_valid = 0;
    chk("f2_opcode", opcode, 8'h25);
    chk("f2_pc", pc, 8'h80);
    chk("f2_addr_after", imem_addr, 8'h10);

    // Timeout after 8 cycles without valid
    load_ir = 1; tick(); load_ir = 0;
    for (int i = 0; i < 7; i++) tick();
    chk("to_req_before", {7'd0, imem_req}, 8'h01);
    tick();
    chk("to_opcode", opcode, 8'h00);
    chk("to_ir_valid", {7'd0, ir_valid}, 8'h01);
    chk("to_err", {7'd0, fetch_err}, 8'h01);
    chk("to_req", {7'd0, imem_req}, 8'h00);

    // Data on the timeout cycle wins
    reset = 1; tick(); reset = 0;
    chk("err_cleared", {7'd0, fetch_err}, 8'h00);
    load_ir = 1; tick(); load_ir = 0;
    for (int i = 0; i < 7; i++) tick();
    imem_valid = 1; imem_rdata = 8'h5C; tick(); imem_valid = 0;
    chk("edge_opcode", opcode, 8'h5C);
    chk("edge_err", {7'd0, fetch_err}, 8'h00);

    // HALT freezes the unit until reset
    reset = 1; tick(); reset = 0;
    load_ir = 1; tick(); load_ir = 0;
    imem_valid = 1; imem_rdata = 8'hF0; tick(); imem_valid = 0;
    chk("halt_set", {7'd0, halted}, 8'h01);
    load_ir = 1; inc_pc = 1; load_pc = 1; reg_target = 8'h99;
    tick(); tick(); tick();
    load_ir = 0; inc_pc = 0; load_pc = 0;
    chk("halt_pc", pc, 8'h00);
    chk("halt_opcode", opcode, 8'hF0);
    chk("halt_req", {7'd0, imem_req}, 8'h00);
    reset = 1; tick(); reset = 0;
    chk("halt_clr", {7'd0, halted}, 8'h00);

    // Reset mid-FETCH, stale valid on the next cycle is ignored
    load_ir = 1; tick(); load_ir = 0;
    reset = 1; tick(); reset = 0;
    imem_valid = 1; imem_rdata = 8'h77; tick(); imem_valid = 0;
    chk("mid_req", {7'd0, imem_req}, 8'h00);
    chk("mid_ir_valid", {7'd0, ir_valid}, 8'h00);
    chk("mid_opcode", opcode, 8'h00);
    tick(); tick();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
